adder_rr_arbiter: RTL and testbench



---
 rtl/adder_arb_pkg.sv | 18 +
 rtl/adder_rr_arbiter_rr_grant.sv | 35 +++
 rtl/adder_rr_arbiter.sv | 110 +++++++++++
 tb/tb_adder_rr_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin shared-adder block: default widths,
// requester limits, output stage state encoding and the id-width helper.
package adder_arb_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int NUM_REQ_MAX = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   // Id width never collapses to zero, so a single requester still gets a 1-bit id.
   function automatic int idw_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid index at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_grant
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = idw_f(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDW-1:0]     rr_ptr,
   output logic [IDW-1:0]     grant,
   output logic               any_valid
);

   int  idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         // Explicit wrap keeps non-power-of-two requester counts correct.
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            grant = IDW'(idx);
            found = 1'b1;
         end
      end
   end

   assign any_valid = |req_valid;

endmodule

// File: rtl/adder_rr_arbiter.sv
// One registered adder shared by NUM_REQ requesters through a round-robin
// arbiter, with a one-entry back-pressurable result stage.
module adder_rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = DATA_W_DEF,
   localparam int IDW     = idw_f(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [DATA_W-1:0]         res_sum,
   output logic                      res_carry,
   output logic [IDW-1:0]            res_id
);

   out_state_t          state_q, state_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic                carry_q, carry_d;
   logic [IDW-1:0]      id_q, id_d;

   logic [IDW-1:0]      grant;
   logic                any_valid;
   logic                can_accept;
   logic                accept;
   logic [DATA_W-1:0]   sel_a, sel_b;
   logic [DATA_W:0]     add_full;

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_grant (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .any_valid (any_valid)
   );

   assign can_accept = (state_q == ST_EMPTY) || res_ready;

   // Ready is a one-hot of the grant, suppressed during reset.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = !rst && can_accept && any_valid && (grant == IDW'(i));
      end
   end

   assign accept = |(req_valid & req_ready);

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == IDW'(i)) begin
            sel_a = req_a[i*DATA_W +: DATA_W];
            sel_b = req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   assign add_full = {1'b0, sel_a} + {1'b0, sel_b};

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      id_d     = id_q;
      if (accept) begin
         state_d  = ST_FULL;
         sum_d    = add_full[DATA_W-1:0];
         carry_d  = add_full[DATA_W];
         id_d     = grant;
         rr_ptr_d = (grant == IDW'(NUM_REQ-1)) ? '0 : grant + IDW'(1);
      end else if (res_ready) begin
         // Drain without refill: payload keeps its last value.
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         id_q     <= id_d;
      end
   end

   assign res_valid = (state_q == ST_FULL);
   assign res_sum   = sum_q;
   assign res_carry = carry_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter (NUM_REQ=4, DATA_W=8).
module tb_adder_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_sum;
   logic        res_carry;
   logic [1:0]  res_id;

   int checks;
   int failures;

   logic [7:0] rr_sum [4];

   adder_rr_arbiter #(
      .NUM_REQ (4),
      .DATA_W  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_carry (res_carry),
      .res_id    (res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rr_sum[0] = 8'h23;
      rr_sum[1] = 8'h33;
      rr_sum[2] = 8'h43;
      rr_sum[3] = 8'h53;

      rst       = 1'b1;
      req_valid = 4'b1111;
      res_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;

      // Reset with every requester asking
      repeat (2) begin
         @(negedge clk); #1;
         chk("rst_ready", req_ready, 4'b0000);
         chk("rst_valid", res_valid, 1'b0);
         chk("rst_sum",   res_sum,   8'h00);
         chk("rst_carry", res_carry, 1'b0);
         chk("rst_id",    res_id,    2'd0);
      end

      // Release: first grant goes to requester 0, single op 0x12+0x34
      @(negedge clk);
      rst = 1'b0;
      set_op(0, 8'h12, 8'h34);
      #1;
      chk("first_grant", req_ready, 4'b0001);
      @(negedge clk); #1;
      chk("op_valid", res_valid, 1'b1);
      chk("op_sum",   res_sum,   8'h46);
      chk("op_carry", res_carry, 1'b0);
      chk("op_id",    res_id,    2'd0);
      req_valid = 4'b0000;

      // Drain with nothing new: valid drops, payload held
      @(negedge clk); #1;
      chk("drain_valid", res_valid, 1'b0);
      chk("drain_sum",   res_sum,   8'h46);

      // Carry: requester 2, 0xFF+0x01
      req_valid = 4'b0100;
      set_op(2, 8'hFF, 8'h01);
      #1;
      chk("carry_ready", req_ready, 4'b0100);
      @(negedge clk); #1;
      chk("carry_sum",   res_sum,   8'h00);
      chk("carry_c",     res_carry, 1'b1);
      chk("carry_id",    res_id,    2'd2);
      chk("carry_valid", res_valid, 1'b1);

      // Simultaneous drain and accept: 0xFF+0xFF
      set_op(2, 8'hFF, 8'hFF);
      #1;
      chk("ff_ready", req_ready, 4'b0100);
      @(negedge clk); #1;
      chk("ff_sum",   res_sum,   8'hFE);
      chk("ff_carry", res_carry, 1'b1);
      chk("ff_id",    res_id,    2'd2);
      chk("ff_valid", res_valid, 1'b1);

      // Reset pulse before round robin so the pointer starts at 0
      rst       = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_op(i, 8'(8'h10 * i + 8'h03), 8'h20);
      #1;
      chk("rst2_ready", req_ready, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst2_valid", res_valid, 1'b0);

      // Round robin, all valid, continuous res_ready
      for (int k = 0; k < 6; k++) begin
         chk("rr_ready", req_ready, 32'(4'b0001 << (k % 4)));
         if (k > 0) begin
            chk("rr_id",    res_id,    32'((k - 1) % 4));
            chk("rr_sum",   res_sum,   rr_sum[(k - 1) % 4]);
            chk("rr_valid", res_valid, 1'b1);
         end
         @(negedge clk); #1;
      end
      chk("rr_id_last",  res_id,  2'd1);
      chk("rr_sum_last", res_sum, 8'h33);

      // Backpressure for 5 cycles with requesters 1 and 3 waiting
      res_ready = 1'b0;
      req_valid = 4'b1010;
      set_op(1, 8'h40, 8'h05);
      set_op(3, 8'h70, 8'h07);
      #1;
      chk("bp_ready", req_ready, 4'b0000);
      repeat (4) begin
         @(negedge clk); #1;
         chk("bp_ready", req_ready, 4'b0000);
         chk("bp_sum",   res_sum,   8'h33);
         chk("bp_id",    res_id,    2'd1);
         chk("bp_valid", res_valid, 1'b1);
      end
      @(negedge clk);
      res_ready = 1'b1;
      #1;
      chk("bp_release_ready", req_ready, 4'b1000);
      @(negedge clk); #1;
      chk("bp_new_sum",   res_sum,   8'h77);
      chk("bp_new_id",    res_id,    2'd3);
      chk("bp_new_valid", res_valid, 1'b1);
      res_ready = 1'b0;
      req_valid = 4'b0000;
      @(negedge clk); #1;
      chk("hold_id3", res_id, 2'd3);

      // Mid-op reset discards the held result
      rst = 1'b1;
      @(negedge clk); #1;
      chk("mid_rst_valid", res_valid, 1'b0);
      chk("mid_rst_id",    res_id,    2'd0);
      chk("mid_rst_sum",   res_sum,   8'h00);
      rst       = 1'b0;
      req_valid = 4'b1001;
      #1;
      chk("mid_rst_grant", req_ready, 4'b0001);

      // Move the pointer off zero, then reset must bring it back
      req_valid = 4'b0010;
      res_ready = 1'b1;
      set_op(1, 8'h01, 8'h02);
      #1;
      chk("ptr_ready", req_ready, 4'b0010);
      @(negedge clk); #1;
      chk("ptr_id",  res_id,  2'd1);
      chk("ptr_sum", res_sum, 8'h03);
      rst       = 1'b1;
      req_valid = 4'b0000;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 4'b0101;
      #1;
      chk("ptr_reset_grant", req_ready, 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
